// File: rtl/riscv_defines.sv
// Shared widths, load/store type encodings and LSU FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package riscv_defines;

    localparam int WORD_WIDTH       = 32;
    localparam int LOAD_TYPE_WIDTH  = 3;
    localparam int STORE_TYPE_WIDTH = 2;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b101;
    localparam logic [2:0] LD_LHU  = 3'b110;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'b00,
        LSU_REQ         = 2'b01,
        LSU_WAIT_RVALID = 2'b10
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module lsu_load_align
    import riscv_defines::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Select width and extension from the load type.
    always_comb begin
        data = shifted;
        case (load_type)
            LD_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            LD_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            LD_LBU:  data = {24'h000000, shifted[7:0]};
            LD_LHU:  data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Write-back stage load/store unit: OBI req/gnt/rvalid handshake, byte lanes, load alignment.
// Latency: non-memory ops same cycle; memory ops 1 accept cycle + REQ until gnt + wait until rvalid.
// Backpressure: stall_o holds the pipeline while a transaction is outstanding; one transaction at a time.
module load_store_unit
    import riscv_defines::*;
#(
    parameter int WORD_WIDTH       = 32,
    parameter int LOAD_TYPE_WIDTH  = 3,
    parameter int STORE_TYPE_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic [WORD_WIDTH-1:0]       ex_data_i,
    input  logic [WORD_WIDTH-1:0]       store_data_i,
    input  logic [LOAD_TYPE_WIDTH-1:0]  load_type_i,
    input  logic [STORE_TYPE_WIDTH-1:0] store_type_i,
    input  logic                        write_en_i,
    output logic                        data_req_o,
    output logic [WORD_WIDTH-1:0]       data_addr_o,
    output logic                        data_we_o,
    output logic [3:0]                  data_be_o,
    output logic [WORD_WIDTH-1:0]       data_wdata_o,
    input  logic [WORD_WIDTH-1:0]       data_rdata_i,
    input  logic                        data_rvalid_i,
    input  logic                        data_gnt_i,
    output logic [WORD_WIDTH-1:0]       writeback_data_o,
    output logic                        writeback_valid_o,
    output logic                        stall_o,
    output logic                        misaligned_o
);

    lsu_state_t                 state_q, state_d;
    logic [LOAD_TYPE_WIDTH-1:0] ld_type_q;
    logic [1:0]                 offset_q;
    logic                       wen_q;

    logic                  is_load, is_store, mem_op, misaligned, accept;
    logic [1:0]            size;
    logic [1:0]            offset;
    logic [3:0]            be_new;
    logic [WORD_WIDTH-1:0] wdata_new;
    logic [WORD_WIDTH-1:0] load_data;
    logic                  stall_raw, wb_valid_raw;

    // Load wins when both type fields are set; size code 01 byte, 10 half, else word.
    assign is_load  = (load_type_i != LD_NONE);
    assign is_store = (store_type_i != ST_NONE);
    assign mem_op   = valid_i & (is_load | is_store);
    assign size     = is_load ? load_type_i[1:0] : store_type_i;
    assign offset   = ex_data_i[1:0];
    assign accept   = (state_q == LSU_IDLE) & mem_op & ~misaligned;

    // Alignment check, byte enables and replicated store data for the incoming op.
    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = store_data_i;
        case (size)
            2'b01: begin
                be_new    = 4'b0001 << offset;
                wdata_new = {4{store_data_i[7:0]}};
            end
            2'b10: begin
                misaligned = offset[0];
                be_new     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{store_data_i[15:0]}};
            end
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata     (data_rdata_i),
        .offset    (offset_q),
        .load_type (ld_type_q),
        .data      (load_data)
    );

    // Next-state logic; gnt and rvalid are only honoured in their own states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:        if (accept)        state_d = LSU_REQ;
            LSU_REQ:         if (data_gnt_i)    state_d = LSU_WAIT_RVALID;
            LSU_WAIT_RVALID: if (data_rvalid_i) state_d = LSU_IDLE;
            default:                            state_d = LSU_IDLE;
        endcase
    end

    // Stall, request and write-back muxing; stall drops in the rvalid cycle.
    always_comb begin
        data_req_o       = (state_q == LSU_REQ);
        stall_raw        = ((state_q != LSU_IDLE) &
                            ~((state_q == LSU_WAIT_RVALID) & data_rvalid_i)) | accept;
        writeback_data_o = ex_data_i;
        wb_valid_raw     = 1'b0;
        if ((state_q == LSU_IDLE) & ~mem_op) begin
            wb_valid_raw = valid_i & write_en_i;
        end else if ((state_q == LSU_WAIT_RVALID) & data_rvalid_i & (ld_type_q != LD_NONE)) begin
            writeback_data_o = load_data;
            wb_valid_raw     = wen_q;
        end
        stall_o           = rst_n & stall_raw;
        writeback_valid_o = rst_n & wb_valid_raw;
    end

    // State, captured request fields and the misaligned pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_wdata_o <= '0;
            ld_type_q    <= LD_NONE;
            offset_q     <= 2'b00;
            wen_q        <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_o <= (state_q == LSU_IDLE) & mem_op & misaligned;
            if (accept) begin
                data_addr_o  <= {ex_data_i[WORD_WIDTH-1:2], 2'b00};
                data_we_o    <= ~is_load;
                data_be_o    <= be_new;
                data_wdata_o <= wdata_new;
                ld_type_q    <= is_load ? load_type_i : LD_NONE;
                offset_q     <= offset;
                wen_q        <= write_en_i;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] ex_data, sdata, rdata;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        wen, gnt, rvalid;

    logic        data_req, data_we, wb_valid, stall, misaligned;
    logic [31:0] data_addr, data_wdata, wb_data;
    logic [3:0]  data_be;

    load_store_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_i           (valid),
        .ex_data_i         (ex_data),
        .store_data_i      (sdata),
        .load_type_i       (ld),
        .store_type_i      (st),
        .write_en_i        (wen),
        .data_req_o        (data_req),
        .data_addr_o       (data_addr),
        .data_we_o         (data_we),
        .data_be_o         (data_be),
        .data_wdata_o      (data_wdata),
        .data_rdata_i      (rdata),
        .data_rvalid_i     (rvalid),
        .data_gnt_i        (gnt),
        .writeback_data_o  (wb_data),
        .writeback_valid_o (wb_valid),
        .stall_o           (stall),
        .misaligned_o      (misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations written by the driver.
    logic        chk_en = 1'b0;
    logic        exp_req, exp_stall, exp_wbv, exp_mis, exp_bus, exp_we, exp_rst;
    logic [31:0] exp_wbd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        mis_next = 1'b0;

    // Observation counters and captures for the literal checks.
    int          req_cnt = 0, wbv_cnt = 0, mis_cnt = 0;
    logic [31:0] last_wbd, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int bytes_of(input logic [2:0] l, input logic [1:0] s);
        if (l != 3'd0) begin
            if (l == 3'd1 || l == 3'd5) return 1;
            if (l == 3'd2 || l == 3'd6) return 2;
            return 4;
        end
        if (s == 2'd1) return 1;
        if (s == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] l, input logic [31:0] rd, input logic [1:0] off);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (l)
            3'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd2: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd5: v = v & 32'hFF;
            3'd6: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input int n, input logic [1:0] off);
        int m;
        m = ((1 << n) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    // Compare process: outputs against the expectations for this cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req", {31'd0, data_req}, {31'd0, exp_req});
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wbv});
            check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
            if (exp_wbv) check("wb_data", wb_data, exp_wbd);
            if (exp_bus) begin
                check("addr", data_addr, exp_addr);
                check("be", {28'd0, data_be}, {28'd0, exp_be});
                check("we", {31'd0, data_we}, {31'd0, exp_we});
                if (exp_we) check("wdata", data_wdata, exp_wdata);
            end
            if (exp_rst) begin
                check("rst_addr", data_addr, 32'd0);
                check("rst_be", {28'd0, data_be}, 32'd0);
                check("rst_we", {31'd0, data_we}, 32'd0);
                check("rst_wdata", data_wdata, 32'd0);
            end
            if (data_req) begin
                req_cnt++;
                cap_addr = data_addr; cap_be = data_be; cap_we = data_we; cap_wdata = data_wdata;
            end
            if (wb_valid) begin
                wbv_cnt++;
                last_wbd = wb_data;
            end
            if (misaligned) mis_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rq, input logic sl, input logic wv, input logic [31:0] wd, input logic bus);
        exp_req = rq; exp_stall = sl; exp_wbv = wv; exp_wbd = wd; exp_bus = bus;
        exp_rst = 1'b0;
        exp_mis = mis_next;
        mis_next = 1'b0;
    endtask

    task automatic idle_cyc();
        valid = 1'b0; ld = 3'($urandom_range(0, 7)); st = 2'($urandom_range(0, 3));
        ex_data = $urandom; gnt = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1));
        rdata = $urandom;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
    endtask

    // Presents one instruction and plays the memory side with gnt after g cycles, rvalid r cycles later.
    task automatic run_op(input logic [2:0] l, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] sd, input logic w, input logic [31:0] rd,
                          input int g, input int r);
        int   n;
        logic is_mem, is_load, mis;
        n       = bytes_of(l, s);
        is_load = (l != 3'd0);
        is_mem  = is_load || (s != 2'd0);
        mis     = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        valid = 1'b1; ld = l; st = s; ex_data = a; sdata = sd; wen = w;
        gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
        if (!is_mem) begin
            set_exp(1'b0, 1'b0, w, a, 1'b0);
            cyc();
            return;
        end
        if (mis) begin
            set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            mis_next = 1'b1;
            cyc();
            return;
        end
        set_exp(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        cyc();
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_be    = model_be(n, a[1:0]);
        exp_we    = !is_load;
        exp_wdata = model_wdata(n, sd);
        for (int k = 0; k <= g; k++) begin
            gnt = (k == g);
            set_exp(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            cyc();
        end
        for (int j = 1; j <= r; j++) begin
            gnt    = 1'($urandom_range(0, 1));
            rvalid = (j == r);
            rdata  = (j == r) ? rd : $urandom;
            set_exp(1'b0, (j != r), (j == r) && is_load && w, model_load(l, rd, a[1:0]), 1'b0);
            cyc();
        end
    endtask

    initial begin
        logic [2:0] lt;
        logic [1:0] stt;
        logic [2:0] ld_codes [5];
        ld_codes[0] = 3'd1; ld_codes[1] = 3'd2; ld_codes[2] = 3'd3;
        ld_codes[3] = 3'd5; ld_codes[4] = 3'd6;

        // Reset: outputs and registered bus fields must be zero; write-back forced low.
        rst_n = 1'b0; valid = 1'b0; ex_data = 0; sdata = 0; ld = 0; st = 0; wen = 0;
        gnt = 0; rvalid = 0; rdata = 0;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
        chk_en = 1'b1;
        valid = 1'b1; wen = 1'b1; ex_data = 32'h55;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        exp_rst = 1'b1;
        cyc();
        rst_n = 1'b1;
        idle_cyc();

        // SW with gnt two cycles after req.
        req_cnt = 0; wbv_cnt = 0;
        run_op(3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0, 2, 1);
        idle_cyc();
        check("sw_req_cycles", req_cnt, 3);
        check("sw_wbv_count", wbv_cnt, 0);
        check("sw_addr", cap_addr, 32'h100);
        check("sw_be", {28'd0, cap_be}, 32'hF);
        check("sw_we", {31'd0, cap_we}, 32'd1);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);

        // LB / LBU from the top byte.
        run_op(3'd1, 2'd0, 32'h203, 32'd0, 1'b1, 32'h80FF1234, 0, 1);
        check("lb_data", last_wbd, 32'hFFFFFF80);
        run_op(3'd5, 2'd0, 32'h203, 32'd0, 1'b1, 32'h80FF1234, 1, 2);
        check("lbu_data", last_wbd, 32'h00000080);

        // SH to upper half with immediate gnt.
        run_op(3'd0, 2'd2, 32'h102, 32'h0000ABCD, 1'b0, 32'd0, 0, 1);
        check("sh_addr", cap_addr, 32'h100);
        check("sh_be", {28'd0, cap_be}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);

        // Misaligned LW is dropped with a single pulse.
        req_cnt = 0; mis_cnt = 0; wbv_cnt = 0;
        run_op(3'd3, 2'd0, 32'h101, 32'd0, 1'b1, 32'd0, 0, 1);
        idle_cyc();
        idle_cyc();
        check("lw_mis_pulses", mis_cnt, 1);
        check("lw_mis_req", req_cnt, 0);
        check("lw_mis_wbv", wbv_cnt, 0);

        // Reset while waiting for rvalid; the late rvalid is ignored.
        wbv_cnt = 0;
        valid = 1'b1; ld = 3'd2; st = 2'd0; ex_data = 32'h300; wen = 1'b1; gnt = 0; rvalid = 0;
        set_exp(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        cyc();
        gnt = 1'b1;
        exp_addr = 32'h300; exp_be = 4'b0011; exp_we = 1'b0; exp_wdata = 32'd0;
        set_exp(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        cyc();
        gnt = 1'b0; rst_n = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc();
        rst_n = 1'b1; valid = 1'b0; ld = 3'd0; gnt = 1'b1; rvalid = 1'b1; rdata = 32'hCAFEF00D;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        exp_rst = 1'b1;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        exp_rst = 1'b1;
        cyc();
        check("rst_mid_wbv", wbv_cnt, 0);

        // Plain ALU op writes back in the same cycle.
        wbv_cnt = 0; req_cnt = 0;
        run_op(3'd0, 2'd0, 32'h55, 32'd0, 1'b1, 32'd0, 0, 1);
        check("alu_data", last_wbd, 32'h55);
        check("alu_wbv_count", wbv_cnt, 1);
        check("alu_req", req_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin lt = 3'd0; stt = 2'd0; end
                2, 3, 4, 5: begin
                    lt  = ld_codes[$urandom_range(0, 4)];
                    stt = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                end
                default: begin lt = 3'd0; stt = 2'($urandom_range(1, 3)); end
            endcase
            run_op(lt, stt, $urandom, $urandom, ($urandom_range(0, 3) != 0), $urandom,
                   $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle_cyc();
        end
        idle_cyc();
        idle_cyc();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
